// File: rtl/sigmoid_result_fifo.sv
// -----------------------------------------------------------------------------
// sigmoid_result_fifo
//   First-word-fall-through FIFO that buffers result pairs {y1, y0} coming out
//   of a two-lane sigmoid pipeline (signed Q5.11 per lane, stored bit-exact).
//   An almost-full flag keeps AFULL_MARGIN entries free so that the pairs
//   already in flight in the upstream pipeline still have room after the
//   source stops issuing. Pairs arriving while the buffer is full with no pop
//   are dropped and recorded in a sticky overflow flag.
//
// Parameters
//   DEPTH        number of entries (power of two, >= 8)
//   AFULL_MARGIN free entries still reserved when afull asserts
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous flush (contents, pointers, overflow)
//   in_valid   in   result pair valid
//   y0_in      in   lane-0 result
//   y1_in      in   lane-1 result
//   afull      out  count >= DEPTH-AFULL_MARGIN (registered)
//   out_valid  out  head entry available (registered)
//   out_ready  in   consumer accepts head entry
//   out_data   out  head entry {y1, y0}
//   count      out  number of stored entries
//   overflow   out  sticky: at least one pair was dropped
// -----------------------------------------------------------------------------
module sigmoid_result_fifo #(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic [15:0]             y0_in,
    input  logic [15:0]             y1_in,
    output logic                    afull,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - AFULL_MARGIN);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          valid_q, valid_d;
    logic          afull_q, afull_d;
    logic          push_s, pop_s, drop_s;

    // Handshake decode; clear suppresses every transfer in its cycle.
    always_comb begin
        pop_s  = valid_q & out_ready & ~clear;
        // A full buffer still accepts a pair when the head leaves in the same cycle.
        push_s = in_valid & ~clear & ((count_q != FULL_CNT) | pop_s);
        drop_s = in_valid & ~clear & (count_q == FULL_CNT) & ~pop_s;
    end

    // Next-state for pointers, occupancy and flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
            ovf_d    = 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (drop_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end
        // Status flags are registered copies decoded from the next count,
        // so they carry no combinational path from any input.
        valid_d = (count_d != {CW{1'b0}});
        afull_d = (count_d >= AFULL_CNT);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            afull_q  <= afull_d;
        end
    end

    // Storage array: no reset needed, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {y1_in, y0_in};
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = valid_q;
    assign afull     = afull_q;
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_sigmoid_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_result_fifo
//   Self-checking bench for sigmoid_result_fifo (DEPTH=16, AFULL_MARGIN=4).
//   A table of directed single-cycle vectors, followed by hand-written
//   sequences for fill/overflow, full push+pop with wrap, streaming, clear
//   and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_sigmoid_result_fifo;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [15:0] y0_in;
    logic [15:0] y1_in;
    logic        afull;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb [$];

    sigmoid_result_fifo #(.DEPTH(16), .AFULL_MARGIN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .y0_in     (y0_in),
        .y1_in     (y1_in),
        .afull     (afull),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        iv;
        logic [15:0] y0;
        logic [15:0] y1;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        int          ec;
        logic        eaf;
        logic        eov;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic ev, input int ec,
                             input logic eaf, input logic eov);
        chk({name, ".valid"},    32'(out_valid), 32'(ev));
        chk({name, ".count"},    32'(count),     32'(ec));
        chk({name, ".afull"},    32'(afull),     32'(eaf));
        chk({name, ".overflow"}, 32'(overflow),  32'(eov));
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic c, input logic iv, input logic [15:0] a,
                       input logic [15:0] b, input logic rdy);
        clear     = c;
        in_valid  = iv;
        y0_in     = a;
        y1_in     = b;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                clr iv  y0        y1        rdy ev  data           cnt af  ov
        vecs[0] = '{1'b0, 1'b1, 16'h0400, 16'h07FB, 1'b0, 1'b1, 32'h07FB0400, 1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 32'h00000000, 0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 32'h7FFF8000, 1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'h1234, 16'hFFFF, 1'b0, 1'b1, 32'h7FFF8000, 2, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'h0001, 16'h0002, 1'b1, 1'b1, 32'hFFFF1234, 2, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 32'h00020001, 1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h5555, 16'hAAAA, 1'b1, 1'b1, 32'hAAAA5555, 1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 32'h00000000, 0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        y0_in     = 16'h0000;
        y1_in     = 16'h0000;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Table-driven basic behaviour
        for (int i = 0; i < 8; i++) begin
            cyc(vecs[i].clr, vecs[i].iv, vecs[i].y0, vecs[i].y1, vecs[i].rdy);
            chk_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].eaf, vecs[i].eov);
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d.data", i), out_data, vecs[i].ed);
            end
        end

        // Fill to 16, afull from 12
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 1'b0);
            sb.push_back({16'h0200 + 16'(i), 16'h0100 + 16'(i)});
            chk($sformatf("fill%0d.count", i), 32'(count), 32'(i + 1));
            chk($sformatf("fill%0d.afull", i), 32'(afull), 32'((i + 1) >= 12));
        end
        chk("fill.head", out_data, 32'h02000100);

        // 17th pair dropped
        cyc(1'b0, 1'b1, 16'hDEAD, 16'hBEEF, 1'b0);
        chk_state("drop", 1'b1, 16, 1'b1, 1'b1);
        chk("drop.head", out_data, 32'h02000100);

        // Full with simultaneous push and pop
        cyc(1'b0, 1'b1, 16'h0300, 16'h0400, 1'b1);
        void'(sb.pop_front());
        sb.push_back(32'h04000300);
        chk_state("fullpp", 1'b1, 16, 1'b1, 1'b1);
        chk("fullpp.head", out_data, 32'h02010101);

        // Drain across pointer wrap, order against scoreboard
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d.data", i), out_data, sb[0]);
            cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
            void'(sb.pop_front());
        end
        chk_state("drained", 1'b0, 0, 1'b0, 1'b1);

        // Clear flushes sticky overflow
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk_state("clr0", 1'b0, 0, 1'b0, 1'b0);

        // Streaming ramp: count stays 1, head is the pair pushed last edge
        for (int k = 0; k < 40; k++) begin
            cyc(1'b0, 1'b1, 16'(k * 3), 16'hF000 + 16'(k), 1'b1);
            chk($sformatf("stream%0d.count", k), 32'(count), 32'd1);
            chk($sformatf("stream%0d.data", k), out_data, {16'hF000 + 16'(k), 16'(k * 3)});
        end
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        chk_state("stream.end", 1'b0, 0, 1'b0, 1'b0);

        // Clear with count=5 and overflow=1, clear wins over in_valid
        for (int i = 0; i < 17; i++) begin
            cyc(1'b0, 1'b1, 16'h0A00 + 16'(i), 16'h0B00, 1'b0);
        end
        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        end
        chk_state("preclr", 1'b1, 5, 1'b0, 1'b1);
        chk("preclr.head", out_data, 32'h0B000A0B);
        cyc(1'b1, 1'b1, 16'h7777, 16'h6666, 1'b0);
        chk_state("clr", 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk_state("clr.idle", 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0);
        chk_state("postclr", 1'b1, 1, 1'b0, 1'b0);
        chk("postclr.head", out_data, 32'h22221111);

        // Async reset between edges at count=7
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 16'h3000 + 16'(i), 16'h3100, 1'b0);
        end
        chk_state("prerst", 1'b1, 7, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("asyncrst", 1'b0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 16'h4242, 16'h2424, 1'b0);
        chk_state("firstpush", 1'b1, 1, 1'b0, 1'b0);
        chk("firstpush.head", out_data, 32'h24244242);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
